pb_event_gen: RTL
=================

// Module: pb_event_gen
// PURPOSE
//  Consumer side of the push-button debouncers: takes NBTN debounced button levels
//  and turns them into single-cycle events in the clk domain for the game control FSM.
//  Events: press, release, auto-repeat while held, one long-press pulse.
//  Sits between the per-button debouncers and the cursor/step/run control logic.
// PARAMETERS
//  NBTN         4      number of buttons handled, each with its own independent channel
//  TICK_DIV     50000  clk cycles per hold tick (1 ms at 50 MHz); must be >= 2
//  REPEAT_DLY   500    ticks held before the first repeat pulse; must be >= 1
//  REPEAT_RATE  100    ticks between later repeat pulses; must be >= 1
//  LONG_TICKS   1000   ticks held before the long_press pulse; must be >= 1
// PORTS
//  clk          in   1     system clock
//  rst          in   1     asynchronous, active-high reset
//  pb_level     in   NBTN  debounced button levels; asynchronous to clk, 1 = pressed
//  press        out  NBTN  1-cycle pulse on press
//  rel          out  NBTN  1-cycle pulse on release
//  rep          out  NBTN  1-cycle auto-repeat pulse
//  long_press   out  NBTN  1-cycle pulse, at most once per hold
//  held         out  NBTN  synchronized, registered button level
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, prescaler 0, every channel IDLE with count 0.
//  - Input sync: 2-flop synchronizer per bit (s1 -> s2), then s2_d = s2 delayed one cycle.
//    held = s2_d.
//  - Edge latency: press is registered from (s2 & ~s2_d). It is high for exactly one
//    cycle, beginning 3 clk edges after the edge that first samples pb_level=1.
//    rel is the same, using (~s2 & s2_d).
//  - Prescaler: one shared counter 0..TICK_DIV-1. tick=1 for one cycle when it wraps.
//    Free-running; not restarted by a press.
//  - Per-channel FSM, hold counter hcnt (saturating, width $clog2(max param+1)+1):
//    IDLE:    on rise -> HOLD, hcnt=0.
//    HOLD:    on tick, hcnt++. When hcnt reaches REPEAT_DLY -> REPEAT,
//             rep pulse, rcnt=0.
//    REPEAT:  on tick, hcnt++ and rcnt++. When rcnt reaches REPEAT_RATE ->
//             rep pulse, rcnt=0.
//    Any state on fall -> IDLE, hcnt=rcnt=0, no rep in that cycle.
//  - long_press: pulses once, in the cycle hcnt becomes LONG_TICKS, in HOLD or REPEAT.
//    Suppressed after that until the next release. hcnt saturates at its maximum.
//  - Tick granularity: the first tick after a press may arrive 1..TICK_DIV cycles later.
//    Timing tolerance is therefore +0/-1 tick.
//  - Event pulses (rep, long_press): registered, asserted the cycle after the tick
//    that satisfies the condition. rep and long_press may coincide.
//  - Channels are fully independent. Simultaneous events on several bits are all
//    reported in the same cycle.
//  - Glitch of one or more cycles at s2 still yields a press/rel pair. Filtering is the
//    debouncer's job and is not repeated here.
//  - Reset mid-hold: everything is cleared. If the button is still down after rst
//    falls, a fresh press appears 3 edges later, because the sync flops reset to 0.
// TESTING  (params NBTN=2, TICK_DIV=4, REPEAT_DLY=3, REPEAT_RATE=2, LONG_TICKS=5)
//  1 rst=1 with pb_level=2'b11 -> all outputs 0. Release rst -> press=2'b11 for one
//    cycle, 3 edges later. held=2'b11.
//  2 pb_level[0] 0->1, held 40 cycles -> press[0] once.
//    rep[0] at hcnt=3, 5, 7, 9 (ticks, +0/-1).
//    long_press[0] exactly once, at hcnt=5. No events on bit 1.
//  3 pb_level[0] 1->0 during REPEAT -> rel[0] one cycle, 3 edges after the edge.
//    No further rep. Re-press -> rep timing restarts from hcnt=0.
//  4 Short tap: high for 6 cycles (<2 ticks) -> press and rel only.
//    rep=0, long_press=0.
//  5 Both bits pressed on the same edge, bit 1 released at tick 4 -> identical press
//    cycles. Bit 0 rep/long_press continue unaffected by bit 1 rel.
//  6 rst asserted for 1 cycle at tick 4 of a hold (pb still 1) -> outputs clear
//    immediately. New press after reset. long_press fires at tick 5 of the new hold.

Source files
------------

// File: rtl/pb_event_if.sv
// Button-level and event bundle between the debouncer bank, the event generator
// and the game control logic.
interface pb_event_if #(
  parameter int NBTN = 4
) ();
  logic [NBTN-1:0] pb_level;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] rel;
  logic [NBTN-1:0] rep;
  logic [NBTN-1:0] long_press;
  logic [NBTN-1:0] held;

  modport master (
    output pb_level,
    input  press,
    input  rel,
    input  rep,
    input  long_press,
    input  held
  );

  modport slave (
    input  pb_level,
    output press,
    output rel,
    output rep,
    output long_press,
    output held
  );
endinterface

// File: rtl/pb_event_gen.sv
// Turns debounced button levels into single-cycle press/release/auto-repeat/long-press
// events, one independent channel per button, all paced by a shared hold-tick prescaler.
module pb_event_gen #(
  parameter int NBTN        = 4,
  parameter int TICK_DIV    = 50000,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int LONG_TICKS  = 1000
) (
  input  logic     clk,
  input  logic     rst,
  pb_event_if.slave bus
);

  localparam int MAX_DR = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int MAXP   = (MAX_DR > LONG_TICKS) ? MAX_DR : LONG_TICKS;
  localparam int HW     = $clog2(MAXP + 1) + 1;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] C_TLAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] C_DLY   = HW'(REPEAT_DLY);
  localparam logic [HW-1:0] C_RATE  = HW'(REPEAT_RATE);
  localparam logic [HW-1:0] C_LONG  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] C_HMAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == C_HMAX) ? v : v + 1'b1;
  endfunction

  logic [NBTN-1:0] r_lvl_p0;
  logic [NBTN-1:0] r_lvl_p1;
  logic [NBTN-1:0] r_lvl_p2;
  logic [NBTN-1:0] r_press;
  logic [NBTN-1:0] r_rel;
  logic [NBTN-1:0] r_rep;
  logic [NBTN-1:0] r_long;
  logic [PW-1:0]   r_pcnt;
  state_t          r_state [NBTN];
  logic [HW-1:0]   r_hcnt  [NBTN];
  logic [HW-1:0]   r_rcnt  [NBTN];

  logic [NBTN-1:0] w_rise;
  logic [NBTN-1:0] w_fall;
  logic            w_tick;
  logic [HW-1:0]   w_hinc  [NBTN];
  logic [HW-1:0]   w_rinc  [NBTN];

  assign w_rise = r_lvl_p1 & ~r_lvl_p2;
  assign w_fall = ~r_lvl_p1 & r_lvl_p2;
  assign w_tick = (r_pcnt == C_TLAST);

  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      w_hinc[i] = sat_inc(r_hcnt[i]);
      w_rinc[i] = r_rcnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl_p0 <= '0;
      r_lvl_p1 <= '0;
      r_lvl_p2 <= '0;
      r_press  <= '0;
      r_rel    <= '0;
      r_rep    <= '0;
      r_long   <= '0;
      r_pcnt   <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_state[i] <= IDLE;
        r_hcnt[i]  <= '0;
        r_rcnt[i]  <= '0;
      end
    end else begin
      // p0/p1: metastability synchronizer; p2: one-cycle-old level for edge detect
      r_lvl_p0 <= bus.pb_level;
      r_lvl_p1 <= r_lvl_p0;
      r_lvl_p2 <= r_lvl_p1;
      r_press  <= w_rise;
      r_rel    <= w_fall;
      r_pcnt   <= w_tick ? '0 : r_pcnt + 1'b1;

      for (int i = 0; i < NBTN; i++) begin
        r_rep[i]  <= 1'b0;
        r_long[i] <= 1'b0;
        // A release wins over any tick landing in the same cycle.
        if (w_fall[i]) begin
          r_state[i] <= IDLE;
          r_hcnt[i]  <= '0;
          r_rcnt[i]  <= '0;
        end else begin
          case (r_state[i])
            IDLE: begin
              if (w_rise[i]) begin
                r_state[i] <= HOLD;
                r_hcnt[i]  <= '0;
                r_rcnt[i]  <= '0;
              end
            end
            HOLD: begin
              if (w_tick) begin
                r_hcnt[i] <= w_hinc[i];
                if (w_hinc[i] == C_LONG) r_long[i] <= 1'b1;
                if (w_hinc[i] == C_DLY) begin
                  r_state[i] <= REPEAT;
                  r_rep[i]   <= 1'b1;
                  r_rcnt[i]  <= '0;
                end
              end
            end
            REPEAT: begin
              if (w_tick) begin
                r_hcnt[i] <= w_hinc[i];
                if (w_hinc[i] == C_LONG) r_long[i] <= 1'b1;
                if (w_rinc[i] == C_RATE) begin
                  r_rep[i]  <= 1'b1;
                  r_rcnt[i] <= '0;
                end else begin
                  r_rcnt[i] <= w_rinc[i];
                end
              end
            end
            default: begin
              r_state[i] <= IDLE;
              r_hcnt[i]  <= '0;
              r_rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.press      = r_press;
  assign bus.rel        = r_rel;
  assign bus.rep        = r_rep;
  assign bus.long_press = r_long;
  assign bus.held       = r_lvl_p2;

endmodule
